// File: rtl/player_key_ctrl.sv
// Frame-rate keycode conditioner in front of player motion: turns raw W into a bounded jump,
// arbitrates A/D/S. Optional air jump is compiled in with `define PLAYER_DOUBLE_JUMP_EN.
//
// state | meaning
// IDLE  | on ground, horizontal/down keys pass through, W edge starts a jump
// JUMP  | emitting KEY_W for a fixed number of frames
// FALL  | emitting 8'h00 so gravity pulls the player down
// COOL  | landed, horizontal keys pass, W ignored until the timer expires
module player_key_ctrl #(
  parameter int unsigned JUMP_FRAMES     = 27,
  parameter int unsigned COOLDOWN_FRAMES = 8,
  parameter logic [9:0]  GROUND_Y        = 10'd377,
  parameter logic [7:0]  KEY_W           = 8'h52,
  parameter logic [7:0]  KEY_S           = 8'h51,
  parameter logic [7:0]  KEY_A           = 8'h50,
  parameter logic [7:0]  KEY_D           = 8'h4F
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [9:0] player_y,
  output logic [7:0] keycode,
  output logic       jump_active,
  output logic [1:0] state_dbg
);

  localparam int unsigned CNT_MAX = (JUMP_FRAMES > COOLDOWN_FRAMES) ? JUMP_FRAMES : COOLDOWN_FRAMES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] JUMP_LOAD = CW'(JUMP_FRAMES - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    JUMP = 2'd1,
    FALL = 2'd2,
    COOL = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    keycode_q, keycode_d;
  logic          jump_active_q, jump_active_d;
  logic          w_prev_q;

  logic       key_w, key_a, key_s, key_d;
  logic       w_rise, grounded;
  logic [7:0] horiz;

  assign key_w    = (keycode0 == KEY_W) || (keycode1 == KEY_W);
  assign key_a    = (keycode0 == KEY_A) || (keycode1 == KEY_A);
  assign key_s    = (keycode0 == KEY_S) || (keycode1 == KEY_S);
  assign key_d    = (keycode0 == KEY_D) || (keycode1 == KEY_D);
  assign w_rise   = key_w && !w_prev_q;
  assign grounded = (player_y >= GROUND_Y);

  always_comb begin
    horiz = 8'h00;
    if (key_a && !key_d)      horiz = KEY_A;
    else if (key_d && !key_a) horiz = KEY_D;
    else if (key_a && key_d)  horiz = 8'h00;
    else if (key_s)           horiz = KEY_S;
  end

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic used_q, used_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    keycode_d = keycode_q;
`ifdef PLAYER_DOUBLE_JUMP_EN
    used_d    = used_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (w_rise && grounded) begin
          state_d   = JUMP;
          cnt_d     = JUMP_LOAD;
          keycode_d = KEY_W;
        end else begin
          keycode_d = horiz;
        end
      end
      JUMP: begin
        // landing is deliberately ignored here: a jump always runs its full length
        keycode_d = KEY_W;
        if (cnt_q == '0) begin
          state_d   = FALL;
          keycode_d = 8'h00;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FALL: begin
        keycode_d = 8'h00;
        if (grounded) begin
          state_d   = COOL;
          cnt_d     = COOL_LOAD;
          keycode_d = horiz;
`ifdef PLAYER_DOUBLE_JUMP_EN
          used_d    = 1'b0;
        end else if (w_rise && !used_q) begin
          state_d   = JUMP;
          cnt_d     = JUMP_LOAD;
          keycode_d = KEY_W;
          used_d    = 1'b1;
`endif
        end
      end
      COOL: begin
        keycode_d = horiz;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
    jump_active_d = (state_d == JUMP) || (state_d == FALL);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      keycode_q     <= 8'h00;
      jump_active_q <= 1'b0;
      w_prev_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      keycode_q     <= keycode_d;
      jump_active_q <= jump_active_d;
      w_prev_q      <= key_w;
    end
  end

`ifdef PLAYER_DOUBLE_JUMP_EN
  always_ff @(posedge frame_clk) begin
    if (Reset) used_q <= 1'b0;
    else       used_q <= used_d;
  end
`endif

  assign keycode     = keycode_q;
  assign jump_active = jump_active_q;
  assign state_dbg   = state_q;

endmodule

// File: doc/player_key_ctrl.md
Name: player_key_ctrl

Overview:
Frame-rate input conditioner sitting directly upstream of the player motion block. It takes the two raw USB HID keycodes from the keyboard interface and produces the single registered keycode that player motion consumes. Raw key levels become a bounded jump sequence: a fixed number of up-frames, a forced fall to ground, then a cooldown. Horizontal and down keys are arbitrated so the player never sees conflicting codes.

Parameters:
JUMP_FRAMES, 27, frames of 8'h52 emitted per jump (27 x 4 px ≈ 108 px rise).
COOLDOWN_FRAMES, 8, frames after landing before a new jump is accepted.
GROUND_Y, 377, player centre Y at or above which the player counts as grounded.
KEY_W, 8'h52, up/jump code.
KEY_S, 8'h51, down code.
KEY_A, 8'h50, left code.
KEY_D, 8'h4F, right code.

Ports:
frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
Reset  in  1  synchronous, active-high reset.
keycode0  in  8  raw HID keycode slot 0 (8'h00 = none).
keycode1  in  8  raw HID keycode slot 1 (8'h00 = none).
player_y  in  10  current player centre Y from the player motion block.
keycode  out  8  registered arbitrated keycode to the player motion block.
jump_active  out  1  high while state is JUMP or FALL.
state_dbg  out  2  current FSM state: IDLE=0, JUMP=1, FALL=2, COOL=3.

Behaviour:
- One clock (frame_clk). Reset is synchronous and active-high. Reset takes priority over all other logic, including mid-jump.
- Reset values: keycode=8'h00, state=IDLE, jump_active=0, state_dbg=0, frame counter=0, w_prev=0.
- Key decode: w/a/d/s are each high when either keycode0 or keycode1 equals the matching code.
- w_rise = w & ~w_prev. w_prev is registered every cycle.
- grounded = (player_y >= GROUND_Y), unsigned 10-bit compare.
- Horizontal arbitration:
  - a&~d gives KEY_A.
  - d&~a gives KEY_D.
  - a&d gives 8'h00 (cancel).
  - Otherwise s gives KEY_S.
  - Otherwise 8'h00.
  - This value is called horiz.
- Outputs are registered, so the response appears one frame after the input.
- FSM:
  - IDLE:
    - If w_rise & grounded: go to JUMP, counter=JUMP_FRAMES-1, next keycode=KEY_W.
    - Otherwise: keycode=horiz.
    - Holding W does not retrigger; W without a rising edge is ignored.
  - JUMP:
    - keycode=KEY_W every frame.
    - Counter decrements each frame.
    - When counter==0: go to FALL, next keycode=8'h00.
    - Exactly JUMP_FRAMES consecutive KEY_W outputs per jump.
  - FALL:
    - keycode=8'h00, so player motion applies gravity. A/D/S are suppressed because they would zero vertical motion.
    - When grounded: go to COOL, counter=COOLDOWN_FRAMES-1.
  - COOL:
    - keycode=horiz.
    - W is ignored.
    - Counter decrements each frame; at 0 go to IDLE.
    - A W edge arriving exactly on the COOL→IDLE frame is not taken; it must occur while in IDLE.
- Counter width is $clog2 of max(JUMP_FRAMES, COOLDOWN_FRAMES)+1. A parameter of 0 is illegal.
- Simultaneous events:
  - w_rise plus A in IDLE: the jump wins.
  - Grounded while in JUMP: ignored; JUMP always runs to completion.
- Codes other than W/A/S/D in either slot are ignored. The same code in both slots counts once.
- jump_active = (state==JUMP)|(state==FALL), registered alongside state.

Optional Feature:
Macro: PLAYER_DOUBLE_JUMP_EN.
- Defined:
  - In FALL, one w_rise (with no grounded requirement) re-enters JUMP with counter=JUMP_FRAMES-1.
  - A used-flag blocks further air jumps.
  - The flag clears on entry to COOL and on Reset.
- Undefined: no air jump, the flag logic is absent, and FALL ignores W entirely.

Test Plan:
- Reset held 2 frames while keycode0=8'h50 → keycode=8'h00, state_dbg=0. First frame after release → keycode=8'h50.
- player_y=377, keycode0=8'h52 pressed and held 40 frames → keycode=8'h52 for exactly 27 frames starting 1 frame after the press, then 8'h00. state_dbg goes 1 then 2.
- During FALL, keycode0=8'h4F, player_y held at 300 → keycode stays 8'h00. Setting player_y=377 → state_dbg=3, keycode=8'h4F next frame. 8 frames later state_dbg=0.
- IDLE, keycode0=8'h50, keycode1=8'h4F → keycode=8'h00. Release keycode1 → keycode=8'h50.
- Reset asserted in the 10th JUMP frame → next frame keycode=8'h00, state_dbg=0, jump_active=0. A fresh W press then yields a full 27-frame jump.
- With PLAYER_DOUBLE_JUMP_EN: W pressed twice during FALL at player_y=300 → the first press gives 27 more KEY_W frames, the second is ignored. Without the macro, both presses are ignored.
